// File: rtl/ofm_drain_pkg.sv
// Shared types and constants for the OFM drain path: FSM states, skid FIFO
// sizing, and the per-lane clamp helper used when OFM_RELU_EN is defined.
package ofm_drain_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   localparam int FIFO_DEPTH = 2;
   localparam int FIFO_CNT_W = 2;
   localparam int LANE_W     = 8;
   localparam int BANK_W     = 2;

   // Clamp one signed lane to zero when negative.
   function automatic logic [LANE_W-1:0] relu_lane(input logic [LANE_W-1:0] lane);
      logic [LANE_W-1:0] res;
      if (lane[LANE_W-1]) begin
         res = {LANE_W{1'b0}};
      end else begin
         res = lane;
      end
      return res;
   endfunction

endpackage

// File: rtl/ofm_skid_fifo.sv
// Two-entry skid FIFO holding word, source bank and last flag. The head entry
// is presented directly, so it stays stable while the consumer stalls.
module ofm_skid_fifo
   import ofm_drain_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_push,
   input  logic [DATA_W-1:0]     i_push_data,
   input  logic [BANK_W-1:0]     i_push_bank,
   input  logic                  i_push_last,
   input  logic                  i_pop,
   output logic [DATA_W-1:0]     o_data,
   output logic [BANK_W-1:0]     o_bank,
   output logic                  o_last,
   output logic                  o_valid,
   output logic [FIFO_CNT_W-1:0] o_count
);

   localparam int ENT_W = DATA_W + BANK_W + 1;

   logic [ENT_W-1:0]      r_mem [FIFO_DEPTH];
   logic                  r_wr_ptr;
   logic                  r_rd_ptr;
   logic [FIFO_CNT_W-1:0] r_count;
   logic                  w_pop;

   assign w_pop = i_pop && (r_count != {FIFO_CNT_W{1'b0}});

   // Storage, pointers and occupancy; pushing into a full FIFO relies on a same-cycle pop.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_mem[i] <= {ENT_W{1'b0}};
         end
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= {FIFO_CNT_W{1'b0}};
      end else begin
         if (i_push) begin
            r_mem[r_wr_ptr] <= {i_push_last, i_push_bank, i_push_data};
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({i_push, w_pop})
            2'b10:   r_count <= r_count + FIFO_CNT_W'(1);
            2'b01:   r_count <= r_count - FIFO_CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign {o_last, o_bank, o_data} = r_mem[r_rd_ptr];
   assign o_valid = (r_count != {FIFO_CNT_W{1'b0}});
   assign o_count = r_count;

endmodule

// File: rtl/ofm_drain.sv
// Drains the OFM banks bank-major, address-ascending, onto a valid/ready stream.
// Define OFM_RELU_EN to clamp negative 8-bit lanes to zero on the way into the FIFO.
module ofm_drain
   import ofm_drain_pkg::*;
#(
   parameter int NUM_BANKS = 4,
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 32
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic [ADDR_W:0]   i_ofm_words,
   output logic [ADDR_W-1:0] o_ofm_rd_addr,
   output logic              o_ofm_rd_en,
   input  logic [DATA_W-1:0] i_ofm_data_0,
   input  logic [DATA_W-1:0] i_ofm_data_1,
   input  logic [DATA_W-1:0] i_ofm_data_2,
   input  logic [DATA_W-1:0] i_ofm_data_3,
   output logic [DATA_W-1:0] o_out_data,
   output logic [BANK_W-1:0] o_out_bank,
   output logic              o_out_last,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic              o_busy,
   output logic              o_done
);

   state_t                r_state;
   state_t                w_state_nxt;
   logic [ADDR_W:0]       r_words;
   logic [ADDR_W-1:0]     r_addr;
   logic [BANK_W-1:0]     r_bank;
   logic                  r_ret_v;
   logic [BANK_W-1:0]     r_ret_bank;
   logic                  r_ret_last;

   logic                  w_issue;
   logic                  w_busy;
   logic                  w_done;
   logic                  w_pop;
   logic                  w_credit_ok;
   logic                  w_last_addr;
   logic                  w_last_bank;
   logic                  w_final_issue;
   logic                  w_drained;
   logic [2:0]            w_occ;
   logic [ADDR_W:0]       w_words_m1;
   logic [FIFO_CNT_W-1:0] w_count;
   logic [DATA_W-1:0]     w_ret_data;
   logic [DATA_W-1:0]     w_push_data;

   assign w_pop       = o_out_valid && i_out_ready;
   // Words already committed to the FIFO after this cycle: stored plus returning minus leaving.
   assign w_occ       = {1'b0, w_count} + {2'b00, r_ret_v} - {2'b00, w_pop};
   assign w_credit_ok = (w_occ < 3'(FIFO_DEPTH));
   assign w_words_m1  = r_words - (ADDR_W+1)'(1);
   assign w_last_addr = ({1'b0, r_addr} == w_words_m1);
   assign w_last_bank = (r_bank == BANK_W'(NUM_BANKS - 1));
   assign w_final_issue = w_issue && w_last_addr && w_last_bank;
   assign w_drained   = (w_count == {FIFO_CNT_W{1'b0}}) && !r_ret_v;

   // FSM state register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (i_start) begin
               if (i_ofm_words == {(ADDR_W+1){1'b0}}) begin
                  w_state_nxt = ST_FLUSH;
               end else begin
                  w_state_nxt = ST_READ;
               end
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_READ: begin
            if (w_final_issue) begin
               w_state_nxt = ST_FLUSH;
            end else begin
               w_state_nxt = ST_READ;
            end
         end
         ST_FLUSH: begin
            if (w_drained) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_FLUSH;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // FSM outputs.
   always_comb begin
      w_issue = 1'b0;
      w_busy  = 1'b0;
      w_done  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_issue = 1'b0;
            w_busy  = 1'b0;
            w_done  = 1'b0;
         end
         ST_READ: begin
            w_issue = w_credit_ok;
            w_busy  = 1'b1;
            w_done  = 1'b0;
         end
         ST_FLUSH: begin
            w_issue = 1'b0;
            w_busy  = 1'b1;
            w_done  = w_drained;
         end
         default: begin
            w_issue = 1'b0;
            w_busy  = 1'b0;
            w_done  = 1'b0;
         end
      endcase
   end

   // Read address/bank counters and the one-cycle return tag pipeline.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_words    <= {(ADDR_W+1){1'b0}};
         r_addr     <= {ADDR_W{1'b0}};
         r_bank     <= {BANK_W{1'b0}};
         r_ret_v    <= 1'b0;
         r_ret_bank <= {BANK_W{1'b0}};
         r_ret_last <= 1'b0;
      end else begin
         if ((r_state == ST_IDLE) && i_start) begin
            r_words <= i_ofm_words;
            r_addr  <= {ADDR_W{1'b0}};
            r_bank  <= {BANK_W{1'b0}};
         end else if (w_issue && !w_final_issue) begin
            if (w_last_addr) begin
               r_addr <= {ADDR_W{1'b0}};
               r_bank <= r_bank + BANK_W'(1);
            end else begin
               r_addr <= r_addr + ADDR_W'(1);
            end
         end
         r_ret_v    <= w_issue;
         r_ret_bank <= r_bank;
         r_ret_last <= w_final_issue;
      end
   end

   // Select the returning bank's word by the delayed bank tag.
   always_comb begin
      w_ret_data = i_ofm_data_0;
      case (r_ret_bank)
         2'd0:    w_ret_data = i_ofm_data_0;
         2'd1:    w_ret_data = i_ofm_data_1;
         2'd2:    w_ret_data = i_ofm_data_2;
         2'd3:    w_ret_data = i_ofm_data_3;
         default: w_ret_data = i_ofm_data_0;
      endcase
   end

   // Optional lane clamp, applied combinationally ahead of the FIFO write.
   always_comb begin
      w_push_data = w_ret_data;
`ifdef OFM_RELU_EN
      for (int l = 0; l < DATA_W / LANE_W; l++) begin
         w_push_data[l*LANE_W +: LANE_W] = relu_lane(w_ret_data[l*LANE_W +: LANE_W]);
      end
`else
      w_push_data = w_ret_data;
`endif
   end

   ofm_skid_fifo #(
      .DATA_W (DATA_W)
   ) u_fifo (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_push      (r_ret_v),
      .i_push_data (w_push_data),
      .i_push_bank (r_ret_bank),
      .i_push_last (r_ret_last),
      .i_pop       (w_pop),
      .o_data      (o_out_data),
      .o_bank      (o_out_bank),
      .o_last      (o_out_last),
      .o_valid     (o_out_valid),
      .o_count     (w_count)
   );

   assign o_ofm_rd_addr = r_addr;
   assign o_ofm_rd_en   = w_issue;
   assign o_busy        = w_busy;
   assign o_done        = w_done;

endmodule

// File: tb/tb_ofm_drain.sv
// Scoreboard bench for ofm_drain: drains push expected words into a queue and
// a negedge monitor pops/compares every handshake and checks stall stability.
module tb_ofm_drain;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 32;

   typedef struct packed {
      logic        last;
      logic [1:0]  bank;
      logic [31:0] data;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [ADDR_W:0]   ofm_words;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_en;
   logic [31:0]       dq0, dq1, dq2, dq3;
   logic [31:0]       out_data;
   logic [1:0]        out_bank;
   logic              out_last;
   logic              out_valid;
   logic              out_ready;
   logic              busy;
   logic              done;

   logic [31:0] mem [4][256];
   exp_t        sb [$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          rd_cnt   = 0;
   int          ready_mode = 0;
   bit          held_v = 1'b0;
   logic [34:0] held_w;

   always #5 clk = ~clk;

   ofm_drain dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_start       (start),
      .i_ofm_words   (ofm_words),
      .o_ofm_rd_addr (rd_addr),
      .o_ofm_rd_en   (rd_en),
      .i_ofm_data_0  (dq0),
      .i_ofm_data_1  (dq1),
      .i_ofm_data_2  (dq2),
      .i_ofm_data_3  (dq3),
      .o_out_data    (out_data),
      .o_out_bank    (out_bank),
      .o_out_last    (out_last),
      .o_out_valid   (out_valid),
      .i_out_ready   (out_ready),
      .o_busy        (busy),
      .o_done        (done)
   );

   function automatic logic [31:0] model_word(input int b, input int a);
      logic [7:0] bb;
      logic [7:0] aa;
      bb = 8'(b);
      aa = 8'(a);
      return {8'h10 + bb, 1'b0, aa[6:0], 8'h2C, 2'b00, bb[1:0], aa[3:0]};
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   // Synchronous bank read model: data one cycle after the read enable.
   always @(posedge clk) begin
      if (rd_en) begin
         dq0 <= mem[0][rd_addr];
         dq1 <= mem[1][rd_addr];
         dq2 <= mem[2][rd_addr];
         dq3 <= mem[3][rd_addr];
      end
   end

   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = ~out_ready;
         default: out_ready = 1'b0;
      endcase
   end

   // Monitor: stall stability, handshake compare, read-issue count.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         held_v = 1'b0;
      end else begin
         if (rd_en) rd_cnt++;
         if (held_v) begin
            check("stall_hold", {out_valid, out_last, out_bank, out_data}, {1'b1, held_w});
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_word", {out_last, out_bank, out_data}, 35'h0);
               n_fail += (n_checks > 0 && {out_last, out_bank, out_data} == 35'h0) ? 1 : 0;
            end else begin
               e = sb.pop_front();
               check("word", {out_last, out_bank, out_data}, {e.last, e.bank, e.data});
            end
         end
         held_v = out_valid && !out_ready;
         held_w = {out_last, out_bank, out_data};
      end
   end

   task automatic drain(input int words, input int mode, input int exp_done,
                        input int exp_first, input int restart_at, input bit relu_case);
      exp_t e;
      int   cyc;
      int   first_v;
      bit   seen;
      rd_cnt = 0;
      for (int b = 0; b < 4; b++) begin
         for (int a = 0; a < words; a++) begin
            e.data = model_word(b, a);
            if (relu_case && b == 0 && a == 0) begin
`ifdef OFM_RELU_EN
               e.data = 32'h00007F01;
`else
               e.data = 32'h80FF7F01;
`endif
            end
            e.bank = 2'(b);
            e.last = (b == 3) && (a == words - 1);
            sb.push_back(e);
         end
      end
      @(negedge clk);
      ready_mode = mode;
      start      = 1'b1;
      ofm_words  = 9'(words);
      @(posedge clk);
      #1 start = 1'b0;
      cyc = 0;
      first_v = -1;
      seen = 1'b0;
      while (!seen && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         if (cyc == restart_at) begin
            start     = 1'b1;
            ofm_words = 9'd7;
         end else begin
            start = 1'b0;
         end
         if (out_valid && first_v < 0) first_v = cyc;
         if (done) seen = 1'b1;
      end
      start = 1'b0;
      check("done_seen", {63'd0, seen}, 64'd1);
      if (exp_done > 0) check("done_cycle", 64'(cyc), 64'(exp_done));
      if (exp_first > 0) check("first_valid_cycle", 64'(first_v), 64'(exp_first));
      check("rd_en_count", 64'(rd_cnt), 64'(4 * words));
      check("scoreboard_empty", 64'(sb.size()), 64'd0);
      @(negedge clk);
      check("done_one_cycle", {62'd0, done, busy}, 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int b = 0; b < 4; b++) begin
         for (int a = 0; a < 256; a++) begin
            mem[b][a] = model_word(b, a);
         end
      end
      dq0 = 32'd0; dq1 = 32'd0; dq2 = 32'd0; dq3 = 32'd0;
      rst = 1'b1;
      start = 1'b0;
      ofm_words = 9'd0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_outputs", {57'd0, out_valid, busy, done, rd_en, out_last, out_bank},
            64'd0);
      check("reset_addr", 64'(rd_addr), 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      drain(3, 0, 15, 3, -1, 1'b0);   // full-rate, 12 words
      drain(4, 1, -1, -1, -1, 1'b0);  // ready toggling
      drain(0, 0, 1, -1, -1, 1'b0);   // empty drain
      drain(5, 0, 23, 3, 6, 1'b0);    // start reasserted mid-drain

      // Fill the FIFO under backpressure, then reset mid-READ.
      @(negedge clk);
      ready_mode = 2;
      out_ready  = 1'b0;
      start      = 1'b1;
      ofm_words  = 9'd4;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (8) @(negedge clk);
      check("full_before_rst", {62'd0, out_valid, busy}, 64'd3);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_read", {60'd0, out_valid, busy, rd_en, done}, 64'd0);
      check("rst_mid_addr", 64'(rd_addr), 64'd0);
      sb.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      ready_mode = 0;
      out_ready  = 1'b1;

      drain(2, 0, 11, 3, -1, 1'b0);   // clean restart from bank 0 addr 0

      mem[0][0] = 32'h80FF7F01;
      drain(1, 0, 7, 3, -1, 1'b1);    // lane clamp vector
      mem[0][0] = model_word(0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule
